ps2_link_sequencer: RTL
=======================

Name: ps2_link_sequencer

Overview:
- Packet-level controller for the PlayStation-style game-controller link.
- Owns the attention line, inter-packet and inter-byte timing, and the command-byte ROM.
- Drives a byte transceiver (shift clock/command/data engine) through a start/done handshake.
- Runs config-enter, set-analog and config-exit once, then repeats button polls. Decodes poll responses into key outputs and re-initialises the controller after repeated bad responses.

Parameters:
- GAP_CYCLES, 2000: clk cycles with attention high between packets.
- BYTE_GAP, 14: idle clk cycles between bytes inside a packet.
- MAX_FAIL, 3: consecutive bad polls before re-initialising (1..15).

Ports:
- clk  in  1  system clock (500 kHz domain)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = run sequencing; 0 = finish current packet, then park
- xfer_start  out  1  one-cycle pulse: transceiver sends xfer_byte
- xfer_byte  out  8  command byte; stable from xfer_start until xfer_done
- xfer_done  in  1  one-cycle pulse: byte exchanged, xfer_rx valid this cycle
- xfer_rx  in  8  byte received from the controller (LSB-first already assembled)
- attention  out  1  active-low controller select
- buttons  out  16  {rx byte5, rx byte4} inverted (1 = pressed)
- sticks  out  32  {LY, LX, RY, RX} raw poll bytes 9..6
- keys_valid  out  1  one-cycle pulse when buttons/sticks update
- configured  out  1  1 after config-exit succeeds
- fail_count  out  4  consecutive bad-poll count, saturating at 15

Behaviour:
- Reset (async, rst_n=0): attention=1, xfer_start=0, xfer_byte=0, buttons=0, sticks=0, keys_valid=0, configured=0, fail_count=0, packet=CFG_ENTER, state=GAP with counter cleared. An in-flight transfer is abandoned. Any late xfer_done is ignored outside XFER.
- Packets (byte index 1..N):
  - CFG_ENTER, N=5: 01 43 00 01 00
  - SET_ANALOG, N=9: 01 44 00 01 03 00 00 00 00
  - CFG_EXIT, N=9: 01 43 00 00 5A 5A 5A 5A 5A
  - POLL, N=9: 01 42 00 00 00 00 00 00 00
- States:
  - IDLE: attention=1. Go to GAP when enable=1.
  - GAP: attention=1. Count GAP_CYCLES cycles, then drop attention to 0 and go to XFER_ISSUE with byte index 1. If enable=0 at entry, go to IDLE instead.
  - XFER_ISSUE: drive xfer_byte from ROM, pulse xfer_start for 1 cycle, go to XFER_WAIT.
  - XFER_WAIT: hold xfer_byte and wait for xfer_done (no timeout). On done, capture xfer_rx into the response buffer at the current index.
    - If index==N, go to CHECK.
    - Otherwise go to BYTE_WAIT.
  - BYTE_WAIT: count BYTE_GAP cycles, increment index, go to XFER_ISSUE.
  - CHECK: raise attention to 1. The packet is good iff response byte 3 == 0x5A.
    - CFG_ENTER good: go to SET_ANALOG.
    - SET_ANALOG good: go to CFG_EXIT.
    - CFG_EXIT good: configured=1, go to POLL.
    - Config packet bad: retry the same packet.
    - POLL good: update buttons/sticks, pulse keys_valid the next cycle, fail_count=0.
    - POLL bad: outputs hold, fail_count+1 (saturating). If the new count >= MAX_FAIL, set configured=0 and packet=CFG_ENTER.
    - Always go to GAP afterwards.
- Latency: xfer_start fires exactly 1 cycle after attention falls. keys_valid fires 1 cycle after CHECK of a good poll.
- enable deasserted mid-packet: the packet completes, including CHECK. The sequencer parks in IDLE from the next GAP entry. Packet position is preserved; on re-enable it resumes with a full GAP.
- xfer_done in the same cycle as the xfer_start pulse: ignored. It is only accepted in XFER_WAIT.
- Counters are sized for GAP_CYCLES up to 4095 and wrap-free: they compare with >= and clear on exit.

Decomposition:
- Shared package ps2_link_pkg:
  - packet enum (CFG_ENTER, SET_ANALOG, CFG_EXIT, POLL)
  - state enum
  - ACK_BYTE=8'h5A
  - packet length constants
  - command ROM function cmd_byte(packet, index)
- One natural sub-module: ps2_cmd_rom, combinational packet/index -> byte/last flag. Everything else stays in this module.

Test Plan:
- Reset then enable=1, transceiver model returns 0x5A at byte 3 → bytes in order 01 43 00 01 00, then 01 44..., then 01 43 00 00 5A...; configured=1 after CFG_EXIT CHECK; each packet preceded by 2000 cycles with attention=1.
- Poll with rx bytes 4=0xFE, 5=0x7F, 6..9=0x80,0x7F,0x10,0xEF → buttons=16'h8001, sticks=32'hEF107F80, one keys_valid pulse.
- Three consecutive polls with byte 3=0xFF → fail_count 1,2,3; configured=0; next packet starts 01 43 00 01 00. A good poll at count 2 instead → fail_count=0.
- SET_ANALOG bad ack once → SET_ANALOG reissued after GAP; CFG_EXIT is not sent until it passes.
- Assert rst_n=0 during XFER_WAIT of byte 5 → attention=1 and xfer_start=0 immediately. After release, the sequence restarts at CFG_ENTER following a full GAP.
- enable=0 at poll byte 4 → packet completes with keys_valid, then attention stays 1 indefinitely. enable=1 → the next packet is POLL after GAP_CYCLES.

Source files
------------

// File: rtl/ps2_link_pkg.sv
// ps2_link_pkg: shared packet/state types, ack constant, packet lengths and command ROM contents
package ps2_link_pkg;
    typedef enum logic [1:0] {CFG_ENTER, SET_ANALOG, CFG_EXIT, POLL} packet_e;
    typedef enum logic [2:0] {ST_IDLE, ST_GAP, ST_XFER_ISSUE, ST_XFER_WAIT, ST_BYTE_WAIT, ST_CHECK} state_e;
    localparam logic [7:0] ACK_BYTE       = 8'h5A;
    localparam logic [3:0] LEN_CFG_ENTER  = 4'd5;
    localparam logic [3:0] LEN_SET_ANALOG = 4'd9;
    localparam logic [3:0] LEN_CFG_EXIT   = 4'd9;
    localparam logic [3:0] LEN_POLL       = 4'd9;
    function automatic logic [3:0] pkt_len(input packet_e p);
        return (p == CFG_ENTER) ? LEN_CFG_ENTER :
               (p == SET_ANALOG) ? LEN_SET_ANALOG :
               (p == CFG_EXIT) ? LEN_CFG_EXIT : LEN_POLL;
    endfunction
    // Byte indices are 1-based; byte 3 is always 00 (the ack slot on the response side).
    function automatic logic [7:0] cmd_byte(input packet_e p, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd1:                   b = 8'h01;
            4'd2:                   b = (p == POLL) ? 8'h42 : (p == SET_ANALOG) ? 8'h44 : 8'h43;
            4'd4:                   b = (p == CFG_ENTER || p == SET_ANALOG) ? 8'h01 : 8'h00;
            4'd5:                   b = (p == SET_ANALOG) ? 8'h03 : (p == CFG_EXIT) ? 8'h5A : 8'h00;
            4'd6, 4'd7, 4'd8, 4'd9: b = (p == CFG_EXIT) ? 8'h5A : 8'h00;
            default:                b = 8'h00;
        endcase
        return b;
    endfunction
endpackage

// File: rtl/ps2_cmd_rom.sv
// ps2_cmd_rom: packet/index -> command byte and last-byte flag (packet, index in; cmd, last out)
module ps2_cmd_rom
    import ps2_link_pkg::*;
(
    input  packet_e    packet,
    input  logic [3:0] index,
    output logic [7:0] cmd,
    output logic       last
);
    assign cmd  = cmd_byte(packet, index);
    assign last = index >= pkt_len(packet);
endmodule

// File: rtl/ps2_link_sequencer.sv
// ps2_link_sequencer: PS2 controller packet sequencer (attention, timing, transceiver handshake, poll decode)
// Ports: clk/rst_n, enable; xfer_start/xfer_byte/xfer_done/xfer_rx to the byte transceiver;
// attention to the controller; buttons/sticks/keys_valid/configured/fail_count status.
module ps2_link_sequencer
    import ps2_link_pkg::*;
#(
    parameter int GAP_CYCLES = 2000,
    parameter int BYTE_GAP   = 14,
    parameter int MAX_FAIL   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        xfer_start,
    output logic [7:0]  xfer_byte,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx,
    output logic        attention,
    output logic [15:0] buttons,
    output logic [31:0] sticks,
    output logic        keys_valid,
    output logic        configured,
    output logic [3:0]  fail_count
);
    state_e      state_q, state_d;
    packet_e     packet_q, packet_d;
    logic [11:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        attention_q, attention_d;
    logic        xfer_start_q, xfer_start_d;
    logic [7:0]  xfer_byte_q, xfer_byte_d;
    logic [15:0] buttons_q, buttons_d;
    logic [31:0] sticks_q, sticks_d;
    logic        keys_valid_q, keys_valid_d;
    logic        configured_q, configured_d;
    logic [3:0]  fail_count_q, fail_count_d;
    logic [7:0]  resp_q [3:9];
    logic [7:0]  resp_d [3:9];
    logic [7:0]  rom_byte;
    logic        rom_last;
    logic        good;
    logic [3:0]  fail_inc;

    ps2_cmd_rom u_rom (
        .packet(packet_q),
        .index (idx_q),
        .cmd   (rom_byte),
        .last  (rom_last)
    );

    assign good     = resp_q[3] == ACK_BYTE;
    assign fail_inc = (fail_count_q == 4'hF) ? 4'hF : fail_count_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        packet_d     = packet_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        attention_d  = attention_q;
        xfer_start_d = 1'b0;
        xfer_byte_d  = xfer_byte_q;
        buttons_d    = buttons_q;
        sticks_d     = sticks_q;
        keys_valid_d = 1'b0;
        configured_d = configured_q;
        fail_count_d = fail_count_q;
        resp_d       = resp_q;
        case (state_q)
            ST_IDLE: state_d = enable ? ST_GAP : ST_IDLE;
            ST_GAP: begin
                // enable is only sampled on the first GAP cycle, so a packet never starts half-gapped
                if (cnt_q == '0 && !enable) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= 12'(GAP_CYCLES - 1)) begin
                    cnt_d       = '0;
                    idx_d       = 4'd1;
                    attention_d = 1'b0;
                    state_d     = ST_XFER_ISSUE;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            ST_XFER_ISSUE: begin
                xfer_byte_d  = rom_byte;
                xfer_start_d = 1'b1;
                state_d      = ST_XFER_WAIT;
            end
            ST_XFER_WAIT: begin
                // a done coinciding with our own start pulse belongs to nothing we issued
                if (xfer_done && !xfer_start_q) begin
                    for (int i = 3; i <= 9; i++)
                        if (idx_q == 4'(i)) resp_d[i] = xfer_rx;
                    state_d = rom_last ? ST_CHECK : ST_BYTE_WAIT;
                end
            end
            ST_BYTE_WAIT: begin
                if (cnt_q >= 12'(BYTE_GAP - 1)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_XFER_ISSUE;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            ST_CHECK: begin
                attention_d = 1'b1;
                state_d     = ST_GAP;
                if (packet_q != POLL) begin
                    if (good) begin
                        packet_d     = packet_e'(packet_q + 2'd1);
                        configured_d = configured_q | (packet_q == CFG_EXIT);
                    end
                end else if (good) begin
                    buttons_d    = ~{resp_q[5], resp_q[4]};
                    sticks_d     = {resp_q[9], resp_q[8], resp_q[7], resp_q[6]};
                    keys_valid_d = 1'b1;
                    fail_count_d = '0;
                end else begin
                    fail_count_d = fail_inc;
                    if (int'(fail_inc) >= MAX_FAIL) begin
                        configured_d = 1'b0;
                        packet_d     = CFG_ENTER;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_GAP;
            packet_q     <= CFG_ENTER;
            cnt_q        <= '0;
            idx_q        <= '0;
            attention_q  <= 1'b1;
            xfer_start_q <= 1'b0;
            xfer_byte_q  <= '0;
            buttons_q    <= '0;
            sticks_q     <= '0;
            keys_valid_q <= 1'b0;
            configured_q <= 1'b0;
            fail_count_q <= '0;
            resp_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            packet_q     <= packet_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            attention_q  <= attention_d;
            xfer_start_q <= xfer_start_d;
            xfer_byte_q  <= xfer_byte_d;
            buttons_q    <= buttons_d;
            sticks_q     <= sticks_d;
            keys_valid_q <= keys_valid_d;
            configured_q <= configured_d;
            fail_count_q <= fail_count_d;
            resp_q       <= resp_d;
        end
    end

    assign attention  = attention_q;
    assign xfer_start = xfer_start_q;
    assign xfer_byte  = xfer_byte_q;
    assign buttons    = buttons_q;
    assign sticks     = sticks_q;
    assign keys_valid = keys_valid_q;
    assign configured = configured_q;
    assign fail_count = fail_count_q;
endmodule
